mc_chroma_ip_nxn: RTL
=====================

Name: mc_chroma_ip_nxn

Overview:
Parametrised chroma fractional interpolator for motion compensation: BLK_W pixels per output row, run-time block height, HEVC 4-tap chroma filter at 1/8-pel in x and y.
Consumes one reference row (BLK_W+3 pixels) per beat and emits one interpolated row per beat.
Adds valid/ready backpressure on both sides, a per-block height field and a busy flag.
Sits between the chroma reference fetch and the rec_mc prediction buffer.

Parameters:
BLK_W, 4, output pixels per row; legal values 4, 8, 16.
PIXEL_WIDTH, 8, sample bit depth; legal range 8..12.
BLK_H_MAX, 16, maximum block height.
HW, 5, width of blk_h_i; equals clog2(BLK_H_MAX+1).

Ports:
clk  in  1  clock.
rstn  in  1  asynchronous active-low reset.
blk_start_i  in  1  one-cycle pulse that starts a block; sampled only in IDLE.
frac_i  in  6  [2:0] fracx, [5:3] fracy in 1/8 pel; latched on blk_start_i.
blk_h_i  in  HW  output rows in the block, 1..BLK_H_MAX; latched on blk_start_i.
ref_valid_i  in  1  reference row valid.
ref_ready_o  out  1  reference row accepted when both valid and ready are 1.
ref_row_i  in  (BLK_W+3)*PIXEL_WIDTH  reference pixels; pixel 0 in the MSBs.
frac_valid_o  out  1  output row valid.
frac_ready_i  in  1  downstream ready.
frac_row_o  out  BLK_W*PIXEL_WIDTH  interpolated row; pixel 0 in the MSBs.
end_oneblk_ip_o  out  1  high together with the block's last output row.
busy_o  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all counters 0, all h-row registers 0.
- FSM states:
  - IDLE -> RUN on blk_start_i. Latch frac_i and blk_h_i; clear in_cnt and out_cnt.
  - RUN -> DRAIN when the last input row (number blk_h+2) is accepted.
  - DRAIN -> IDLE when the last output row handshakes.
- ref_ready_o = (state==RUN) && (!frac_valid_o || frac_ready_i).
  - Low in IDLE and DRAIN.
  - A blk_start_i pulse in RUN or DRAIN is ignored.
- Horizontal stage (combinational, on the accepted row):
  - h[j] = (sum over k=0..3 of cx[k]*p[j+k]) >>> (PIXEL_WIDTH-8), for j=0..BLK_W-1.
  - Signed result, width PIXEL_WIDTH+8.
- h-row window: a 3-deep shift register of h rows, loaded on every accepted row.
- Vertical stage:
  - Applies once in_cnt >= 3 (the 4th and later accepted rows).
  - v[j] = sum of cy[k]*hrow_k[j], with hrow_3 the current row. Signed, width PIXEL_WIDTH+16.
  - out = clip(((v >>> 6) + (1 << (13-PIXEL_WIDTH))) >>> (14-PIXEL_WIDTH), 0, 2^PIXEL_WIDTH-1).
  - This is bit-exact to HEVC uni-prediction for every fracx/fracy combination, zero included.
- Output register:
  - Loaded on the same handshake, so frac_valid_o rises 1 cycle after input row 4 is accepted.
  - Steady-state throughput is 1 row per cycle.
  - Holds value and valid while frac_valid_o && !frac_ready_i.
  - Clears valid on handshake when no new row loads.
- Block size: exactly blk_h+3 input rows and blk_h output rows per block.
- end_oneblk_ip_o = frac_valid_o && (out_cnt == blk_h-1). Held under backpressure.
- Boundary conditions:
  - blk_h_i=0 is treated as 1.
  - blk_h_i > BLK_H_MAX is saturated to BLK_H_MAX.
  - A new blk_start_i arriving in the same cycle that DRAIN->IDLE completes is ignored; it is accepted from IDLE on the next cycle.
  - Reset mid-block returns immediately to the reset state; no partial row is emitted.
- Coefficients cx/cy by frac value:
  - 0: {0,64,0,0}
  - 1: {-2,58,10,-2}
  - 2: {-4,54,16,-2}
  - 3: {-6,46,28,-4}
  - 4: {-4,36,36,-4}
  - 5: {-4,28,46,-6}
  - 6: {-2,16,54,-4}
  - 7: {-2,10,58,-2}

Decomposition:
- Shared package / enc_defines include holds:
  - the chroma coefficient table as a function of 3-bit frac;
  - PIXEL_WIDTH;
  - the derived widths H_W=PIXEL_WIDTH+8 and V_W=PIXEL_WIDTH+16.
- Sub-module mc_chroma_tap4: a signed 4-tap multiply-accumulate with a 3-bit frac select and parametrised input width.
  - Instantiated BLK_W times horizontally (unsigned pixel inputs, zero-extended).
  - Instantiated BLK_W times vertically (signed h inputs).
- The top level holds the FSM, counters, h-row window, rounding/clip and the output register.

Test Plan:
1. frac=0, blk_h=4, BLK_W=4, every pixel 100 -> 4 output rows, all pixels 100; end_oneblk_ip_o on row 4; busy_o falls the cycle after the last handshake.
2. fracx=3, fracy=5, every pixel 200 -> every output pixel 200; first frac_valid_o one cycle after the 4th accepted row.
3. fracx=4, fracy=0, row pattern 0,255,255,0,... -> positions with h=18360 give 255 (clip high); pattern 255,0,0,255 gives -2040 -> 0 (clip low).
4. Ramp input p[j]=10*j (same every row), fracx=2, fracy=0 -> out[j] = 10*j + 13 after rounding; check against the golden model.
5. frac_ready_i low for 5 cycles mid-block -> ref_ready_o low, frac_row_o and valid held stable, no rows lost or duplicated, 7 inputs give 4 outputs.
6. rstn asserted after 2 output rows of a blk_h=8 block -> all outputs 0, IDLE; a following block with blk_h=2 and fracx=fracy=1 produces exactly 2 correct rows.

Source files
------------

// File: rtl/mc_chroma_ip_nxn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_chroma_ip_nxn_pkg
//  Description : Shared types, derived widths and the HEVC 4-tap chroma
//                coefficient table for the chroma fractional interpolator.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_chroma_ip_nxn_pkg;

    localparam int DEF_PIXEL_WIDTH = 8;
    localparam int COEF_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Horizontal intermediate width (signed h samples)
    function automatic int h_width(input int pw);
        return pw + 8;
    endfunction

    // Vertical accumulator width (signed v samples)
    function automatic int v_width(input int pw);
        return pw + 16;
    endfunction

    // Tap k (0..3) of the chroma filter for a 1/8-pel phase
    function automatic logic signed [COEF_W-1:0] chroma_coef(input logic [2:0] frac,
                                                            input logic [1:0] k);
        logic [3:0][COEF_W-1:0] w_taps;
        w_taps = '0;
        // Packed as {c3, c2, c1, c0}
        case (frac)
            3'd0:    w_taps = {8'sd0,  8'sd0,  8'sd64, 8'sd0};
            3'd1:    w_taps = {-8'sd2, 8'sd10, 8'sd58, -8'sd2};
            3'd2:    w_taps = {-8'sd2, 8'sd16, 8'sd54, -8'sd4};
            3'd3:    w_taps = {-8'sd4, 8'sd28, 8'sd46, -8'sd6};
            3'd4:    w_taps = {-8'sd4, 8'sd36, 8'sd36, -8'sd4};
            3'd5:    w_taps = {-8'sd6, 8'sd46, 8'sd28, -8'sd4};
            3'd6:    w_taps = {-8'sd4, 8'sd54, 8'sd16, -8'sd2};
            default: w_taps = {-8'sd2, 8'sd58, 8'sd10, -8'sd2};
        endcase
        return $signed(w_taps[k]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_chroma_ip_nxn_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_chroma_ip_nxn_if
//  Description : Block control, reference-row and output-row handshake
//                signals of the chroma interpolator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mc_chroma_ip_nxn_if #(
    parameter int BLK_W       = 4,
    parameter int PIXEL_WIDTH = 8,
    parameter int HW          = 5
);
    logic                              blk_start_i;
    logic [5:0]                        frac_i;
    logic [HW-1:0]                     blk_h_i;
    logic                              ref_valid_i;
    logic                              ref_ready_o;
    logic [(BLK_W+3)*PIXEL_WIDTH-1:0]  ref_row_i;
    logic                              frac_valid_o;
    logic                              frac_ready_i;
    logic [BLK_W*PIXEL_WIDTH-1:0]      frac_row_o;
    logic                              end_oneblk_ip_o;
    logic                              busy_o;

    // Interpolator side
    modport slave (
        input  blk_start_i, frac_i, blk_h_i, ref_valid_i, ref_row_i, frac_ready_i,
        output ref_ready_o, frac_valid_o, frac_row_o, end_oneblk_ip_o, busy_o
    );

    // Fetch / prediction-buffer side
    modport master (
        output blk_start_i, frac_i, blk_h_i, ref_valid_i, ref_row_i, frac_ready_i,
        input  ref_ready_o, frac_valid_o, frac_row_o, end_oneblk_ip_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/mc_chroma_tap4.sv
`default_nettype none
// ============================================================================
//  Module      : mc_chroma_tap4
//  Description : Signed 4-tap multiply-accumulate with a 3-bit phase select.
//                Inputs are zero- or sign-extended depending on SIGNED_IN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_chroma_tap4
    import mc_chroma_ip_nxn_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter bit SIGNED_IN = 1'b0,
    parameter int ACC_W     = 16
) (
    input  logic [2:0]             i_frac,
    input  logic [3:0][IN_W-1:0]   i_x,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [ACC_W-1:0] w_x [4];

    for (genvar k = 0; k < 4; k++) begin : g_ext
        if (SIGNED_IN) begin : g_sext
            assign w_x[k] = ACC_W'($signed(i_x[k]));
        end else begin : g_zext
            assign w_x[k] = ACC_W'(i_x[k]);
        end
    end

    // Sum of coefficient * sample over the four taps
    always_comb begin
        o_acc = '0;
        for (int k = 0; k < 4; k++) begin
            o_acc = o_acc + (ACC_W'(chroma_coef(i_frac, 2'(k))) * w_x[k]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_chroma_ip_nxn.sv
`default_nettype none
// ============================================================================
//  Module      : mc_chroma_ip_nxn
//  Description : Chroma 1/8-pel separable interpolator. One reference row of
//                BLK_W+3 pixels in, one filtered row of BLK_W pixels out per
//                beat, with a 3-row window of horizontal results feeding the
//                vertical filter.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_chroma_ip_nxn
    import mc_chroma_ip_nxn_pkg::*;
#(
    parameter int BLK_W       = 4,
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int BLK_H_MAX   = 16,
    parameter int HW          = 5
) (
    input  logic               clk,
    input  logic               rstn,
    mc_chroma_ip_nxn_if.slave  bus
);

    localparam int C_H_W       = h_width(PIXEL_WIDTH);
    localparam int C_V_W       = v_width(PIXEL_WIDTH);
    localparam int C_N_REF     = BLK_W + 3;
    localparam int C_CW        = HW + 1;
    localparam int C_H_SHIFT   = PIXEL_WIDTH - 8;
    localparam int C_OUT_SHIFT = 14 - PIXEL_WIDTH;
    localparam logic signed [C_V_W-1:0] C_RND     = C_V_W'(1 << (13 - PIXEL_WIDTH));
    localparam logic signed [C_V_W-1:0] C_PIX_MAX = C_V_W'((1 << PIXEL_WIDTH) - 1);
    localparam logic [HW-1:0]           C_H_MAX   = HW'(BLK_H_MAX);

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic [5:0]                         r_frac;
    logic [HW-1:0]                      r_blk_h;
    logic [C_CW-1:0]                    r_in_cnt;
    logic [HW-1:0]                      r_out_cnt;
    logic [BLK_W-1:0][C_H_W-1:0]        r_hrow0;
    logic [BLK_W-1:0][C_H_W-1:0]        r_hrow1;
    logic [BLK_W-1:0][C_H_W-1:0]        r_hrow2;
    logic                               r_valid;
    logic [BLK_W*PIXEL_WIDTH-1:0]       r_row;

    logic                               w_ref_ready;
    logic                               w_ref_acc;
    logic                               w_out_hs;
    logic                               w_last_in;
    logic                               w_last_out;
    logic                               w_load;
    logic                               w_start;
    logic [HW-1:0]                      w_blk_h_sat;
    logic [C_N_REF-1:0][PIXEL_WIDTH-1:0] w_ref_pix;
    logic [BLK_W-1:0][C_H_W-1:0]        w_hrow_cur;
    logic signed [C_H_W-1:0]            w_hacc [BLK_W];
    logic signed [C_V_W-1:0]            w_v    [BLK_W];
    logic signed [C_V_W-1:0]            w_rnd  [BLK_W];
    logic [BLK_W*PIXEL_WIDTH-1:0]       w_pix_row;

    // A new row may enter only while running and the output slot is free or emptying
    assign w_ref_ready = (r_state == ST_RUN) && (!r_valid || bus.frac_ready_i);
    assign w_ref_acc   = bus.ref_valid_i && w_ref_ready;
    assign w_out_hs    = r_valid && bus.frac_ready_i;
    assign w_start     = (r_state == ST_IDLE) && bus.blk_start_i;
    assign w_last_in   = w_ref_acc && (r_in_cnt == ({1'b0, r_blk_h} + C_CW'(2)));
    assign w_last_out  = r_valid && (r_out_cnt == (r_blk_h - HW'(1)));
    assign w_load      = w_ref_acc && (r_in_cnt >= C_CW'(3));

    assign bus.ref_ready_o     = w_ref_ready;
    assign bus.frac_valid_o    = r_valid;
    assign bus.frac_row_o      = r_row;
    assign bus.end_oneblk_ip_o = w_last_out;
    assign bus.busy_o          = (r_state != ST_IDLE);

    // Height of zero behaves as one row; oversize heights clamp to the maximum
    always_comb begin
        w_blk_h_sat = bus.blk_h_i;
        if (bus.blk_h_i == '0) begin
            w_blk_h_sat = HW'(1);
        end else if (bus.blk_h_i > C_H_MAX) begin
            w_blk_h_sat = C_H_MAX;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.blk_start_i)        w_state_nxt = ST_RUN;
            ST_RUN:   if (w_last_in)              w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_out_hs && w_last_out) w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    // Block parameters and row counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frac    <= '0;
            r_blk_h   <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (w_start) begin
            r_frac    <= bus.frac_i;
            r_blk_h   <= w_blk_h_sat;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_ref_acc) r_in_cnt  <= r_in_cnt + C_CW'(1);
            if (w_out_hs)  r_out_cnt <= r_out_cnt + HW'(1);
        end
    end

    // Window of the three previous horizontal rows, oldest in r_hrow0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hrow0 <= '0;
            r_hrow1 <= '0;
            r_hrow2 <= '0;
        end else if (w_ref_acc) begin
            r_hrow0 <= r_hrow1;
            r_hrow1 <= r_hrow2;
            r_hrow2 <= w_hrow_cur;
        end
    end

    // Output row register: load with the fourth and later rows, hold under backpressure
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_row   <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_row   <= w_pix_row;
        end else if (w_out_hs) begin
            r_valid <= 1'b0;
        end
    end

    // Pixel 0 sits in the MSBs of the reference row
    for (genvar k = 0; k < C_N_REF; k++) begin : g_ref
        assign w_ref_pix[k] = bus.ref_row_i[(C_N_REF-1-k)*PIXEL_WIDTH +: PIXEL_WIDTH];
    end

    for (genvar j = 0; j < BLK_W; j++) begin : g_col
        mc_chroma_tap4 #(
            .IN_W      (PIXEL_WIDTH),
            .SIGNED_IN (1'b0),
            .ACC_W     (C_H_W)
        ) u_htap (
            .i_frac (r_frac[2:0]),
            .i_x    ({w_ref_pix[j+3], w_ref_pix[j+2], w_ref_pix[j+1], w_ref_pix[j]}),
            .o_acc  (w_hacc[j])
        );

        assign w_hrow_cur[j] = w_hacc[j] >>> C_H_SHIFT;

        mc_chroma_tap4 #(
            .IN_W      (C_H_W),
            .SIGNED_IN (1'b1),
            .ACC_W     (C_V_W)
        ) u_vtap (
            .i_frac (r_frac[5:3]),
            .i_x    ({w_hrow_cur[j], r_hrow2[j], r_hrow1[j], r_hrow0[j]}),
            .o_acc  (w_v[j])
        );

        assign w_rnd[j] = ((w_v[j] >>> 6) + C_RND) >>> C_OUT_SHIFT;

        assign w_pix_row[(BLK_W-1-j)*PIXEL_WIDTH +: PIXEL_WIDTH] =
            (w_rnd[j] < 0)         ? {PIXEL_WIDTH{1'b0}} :
            (w_rnd[j] > C_PIX_MAX) ? {PIXEL_WIDTH{1'b1}} :
                                     w_rnd[j][PIXEL_WIDTH-1:0];
    end

endmodule
`default_nettype wire
